// File: rtl/landing_lights_param.sv
// Runway landing-light pattern generator: calm edge/centre alternation or wrapping single-LED sweep.
// Out/step register one cycle after a prescaler tick; enable=0 freezes everything, w=11 holds the pattern.
module landing_lights_param #(
  parameter int N        = 3,
  parameter int TICK_DIV = 1,
  localparam int CW      = $clog2(TICK_DIV) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   w,
  input  logic         enable,
  output logic [N-1:0] out,
  output logic         step
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] LAST     = PW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    CALM_EDGE,
    CALM_CENTRE,
    SWEEP
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pos_q, pos_d;
  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          adv;

  function automatic logic [N-1:0] pattern(input state_t s, input logic [PW-1:0] p);
    logic [N-1:0] v;
    v = '0;
    case (s)
      CALM_EDGE: begin
        v[0]   = 1'b1;
        v[N-1] = 1'b1;
      end
      CALM_CENTRE: begin
        v[(N-1)/2] = 1'b1;
        v[N/2]     = 1'b1;
      end
      default: v = N'(1) << p;
    endcase
    return v;
  endfunction

  assign tick = enable && (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    adv     = 1'b0;
    if (tick) begin
      case (w)
        2'b00: begin
          adv     = 1'b1;
          state_d = (state_q == CALM_EDGE) ? CALM_CENTRE : CALM_EDGE;
        end
        2'b01: begin
          adv = 1'b1;
          if (state_q != SWEEP) begin
            state_d = SWEEP;
            pos_d   = '0;
          end else begin
            pos_d = (pos_q == LAST) ? '0 : pos_q + 1'b1;
          end
        end
        2'b10: begin
          adv = 1'b1;
          if (state_q != SWEEP) begin
            state_d = SWEEP;
            pos_d   = LAST;
          end else begin
            pos_d = (pos_q == '0) ? LAST : pos_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // out is reloaded only when a pattern step happens, so it always mirrors state_q/pos_q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= CALM_EDGE;
      pos_q   <= '0;
      cnt_q   <= '0;
      step    <= 1'b0;
      out     <= pattern(CALM_EDGE, '0);
    end else begin
      if (enable) cnt_q <= tick ? '0 : cnt_q + 1'b1;
      state_q <= state_d;
      pos_q   <= pos_d;
      step    <= adv;
      if (adv) out <= pattern(state_d, pos_d);
    end
  end

endmodule

// File: tb/tb_landing_lights_param.sv
// Drives four parameterisations in lockstep and checks each against a behavioural model.
module tb_landing_lights_param;

  logic       clk;
  logic       reset;
  logic [1:0] w;
  logic       enable;
  logic [2:0] out_a;
  logic [4:0] out_b;
  logic [3:0] out_c;
  logic [4:0] out_d;
  logic [3:0] stp;
  logic [7:0] obs[4];

  int errors = 0;
  int checks = 0;

  const int NN[4] = '{3, 5, 4, 5};
  const int TD[4] = '{1, 4, 2, 1};

  // model: mode 0 = calm edge, 1 = calm centre, 2 = sweep
  int mmode[4];
  int mpos[4];
  int mcnt[4];
  bit mstep[4];

  landing_lights_param #(.N(3), .TICK_DIV(1)) u_a (
    .clk(clk), .reset(reset), .w(w), .enable(enable), .out(out_a), .step(stp[0]));
  landing_lights_param #(.N(5), .TICK_DIV(4)) u_b (
    .clk(clk), .reset(reset), .w(w), .enable(enable), .out(out_b), .step(stp[1]));
  landing_lights_param #(.N(4), .TICK_DIV(2)) u_c (
    .clk(clk), .reset(reset), .w(w), .enable(enable), .out(out_c), .step(stp[2]));
  landing_lights_param #(.N(5), .TICK_DIV(1)) u_d (
    .clk(clk), .reset(reset), .w(w), .enable(enable), .out(out_d), .step(stp[3]));

  assign obs[0] = {5'b0, out_a};
  assign obs[1] = {3'b0, out_b};
  assign obs[2] = {4'b0, out_c};
  assign obs[3] = {3'b0, out_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pattern(input int mode, input int pos, input int n);
    int v;
    case (mode)
      0:       v = 1 + (1 << (n - 1));
      1:       v = (1 << ((n - 1) / 2)) | (1 << (n / 2));
      default: v = 1 << pos;
    endcase
    return v[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mmode[i] = 0;
      mpos[i]  = 0;
      mcnt[i]  = 0;
      mstep[i] = 0;
    end
  endtask

  task automatic model_clock();
    bit tk;
    if (!reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < 4; i++) begin
        mstep[i] = 0;
        if (enable) begin
          tk      = (mcnt[i] == TD[i] - 1);
          mcnt[i] = (mcnt[i] + 1) % TD[i];
          if (tk && w != 2'b11) begin
            mstep[i] = 1;
            if (w == 2'b00) begin
              mmode[i] = (mmode[i] == 0) ? 1 : 0;
            end else if (mmode[i] != 2) begin
              mmode[i] = 2;
              mpos[i]  = (w == 2'b01) ? 0 : NN[i] - 1;
            end else if (w == 2'b01) begin
              mpos[i] = (mpos[i] + 1) % NN[i];
            end else begin
              mpos[i] = (mpos[i] + NN[i] - 1) % NN[i];
            end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out[%0d]", i), obs[i], pattern(mmode[i], mpos[i], NN[i]));
      check($sformatf("step[%0d]", i), {7'b0, stp[i]}, {7'b0, mstep[i]});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clock();
    #1;
    check_model();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    cyc();
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] seq_a[8];
    logic [7:0] seq_b[3];
    logic [7:0] seq_d[3];
    seq_a = '{8'b010, 8'b101, 8'b010, 8'b101, 8'b001, 8'b010, 8'b100, 8'b001};
    seq_b = '{8'b10000, 8'b01000, 8'b00100};
    seq_d = '{8'b00010, 8'b00001, 8'b10000};

    reset  = 1'b1;
    w      = 2'b00;
    enable = 1'b1;
    model_reset();
    #2 reset = 1'b0;
    #1;
    check_model();
    check("a_reset", obs[0], 8'b101);
    check("b_reset", obs[1], 8'b10001);
    check("c_reset", obs[2], 8'b1001);
    cyc();
    reset = 1'b1;

    // calm alternation then MSB-ward sweep with wrap, on the N=3 divide-by-1 unit
    for (int k = 0; k < 8; k++) begin
      w = (k < 4) ? 2'b00 : 2'b01;
      cyc();
      check($sformatf("a_seq%0d", k), obs[0], seq_a[k]);
      check($sformatf("a_step%0d", k), {7'b0, stp[0]}, 8'd1);
    end
    w = 2'b00;
    cyc();
    check("a_back_to_edge", obs[0], 8'b101);

    // N=5 divide-by-4: LSB-ward sweep entered at MSB, one step every fourth cycle
    pulse_reset();
    w = 2'b10;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("b_step%0d", k), {7'b0, stp[1]}, (k % 4 == 0) ? 8'd1 : 8'd0);
      if (k % 4 == 0) check($sformatf("b_out%0d", k), obs[1], seq_b[k/4-1]);
    end

    // N=5 divide-by-1: reversal continues from the current position
    pulse_reset();
    w = 2'b01;
    repeat (3) cyc();
    check("d_pos2", obs[3], 8'b00100);
    w = 2'b10;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check($sformatf("d_rev%0d", k), obs[3], seq_d[k]);
    end

    // N=4 divide-by-2: enable freeze, hold code, then calm centre
    pulse_reset();
    w = 2'b01;
    repeat (6) cyc();
    check("c_sweep", obs[2], 8'b0100);
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("c_frz%0d", k), obs[2], 8'b0100);
      check($sformatf("c_frz_step%0d", k), {7'b0, stp[2]}, 8'd0);
    end
    enable = 1'b1;
    w = 2'b11;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check($sformatf("c_hold%0d", k), obs[2], 8'b0100);
      check($sformatf("c_hold_step%0d", k), {7'b0, stp[2]}, 8'd0);
    end
    w = 2'b00;
    repeat (4) cyc();
    check("c_centre", obs[2], 8'b0110);

    // asynchronous reset between edges mid-sweep
    pulse_reset();
    w = 2'b01;
    repeat (6) cyc();
    check("c_pre_async", obs[2], 8'b0100);
    #2 reset = 1'b0;
    model_reset();
    #1;
    check("c_async", obs[2], 8'b1001);
    check_model();
    cyc();
    reset = 1'b1;
    w = 2'b01;
    repeat (2) cyc();
    check("c_after_async", obs[2], 8'b0001);

    // randomized traffic with occasional asynchronous resets
    for (int k = 0; k < 600; k++) begin
      w      = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) begin
        #2 reset = 1'b0;
        model_reset();
        #1;
        check_model();
      end
      cyc();
      reset = 1'b1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/landing_lights_param.md
Name: landing_lights_param

Overview:
Parametrised runway landing-light pattern generator, successor to the fixed 3-LED wind-indicator FSM. Drives an N-wide LED bank from a 2-bit wind-direction input. Calm wind alternates an edges/centre pattern; wind in either direction sweeps a single lit LED across the bank with wrap-around. Patterns advance at a programmable rate from an internal prescaler, so the block can run directly from the board clock.

Parameters:
N, 3, number of LEDs; legal range N >= 3
TICK_DIV, 1, clock cycles per pattern step; legal range TICK_DIV >= 1
CW, $clog2(TICK_DIV)+1, derived prescaler counter width; not overridden

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset; 0 = in reset
w  input  2  wind code: 00 calm, 01 sweep toward MSB, 10 sweep toward LSB, 11 hold
enable  input  1  1 = run; 0 = freeze prescaler and pattern
out  output  N  LED drive, registered; bit 0 = LSB/rightmost LED
step  output  1  registered one-cycle pulse, coincident with each new out value

Behaviour:
- Single clock domain (clk). Reset is asynchronous, active-low.
  - On reset = 0, immediately: state = CALM_EDGE, pos = 0, prescaler = 0, step = 0, out = edge pattern (bits 0 and N-1 set; N=3 -> 101).
  - Normal operation resumes on the first rising clk edge after reset returns to 1.
  - Reset asserted mid-sweep aborts the sweep; no partial state is retained.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while enable = 1; wraps to 0.
  - tick = enable AND (count == TICK_DIV-1). With TICK_DIV=1, tick = enable.
  - enable = 0 holds the count, out and state; step = 0.
- All state/pos/out updates occur only on edges where tick = 1. w is sampled only on those edges.
- States:
  - CALM_EDGE: out = bits 0 and N-1 set.
  - CALM_CENTRE: out = bits floor((N-1)/2) and ceil((N-1)/2) set (N=3 -> 010, N=4 -> 0110, N=5 -> 00100).
  - SWEEP: out = one-hot at pos (0..N-1).
- Transitions on tick:
  - w=00: CALM_EDGE <-> CALM_CENTRE (alternate); SWEEP -> CALM_EDGE.
  - w=01 from either calm state: -> SWEEP, pos = 0. In SWEEP: pos = pos+1; N-1 wraps to 0.
  - w=10 from either calm state: -> SWEEP, pos = N-1. In SWEEP: pos = pos-1; 0 wraps to N-1.
  - Direction reversal in SWEEP continues from the current pos; the sweep does not restart.
  - w=11: hold. State, pos and out are unchanged and step = 0. The prescaler keeps running.
- out is a pure function of registered state/pos, so there are no combinational paths from w or enable to out.
- step = 1 for exactly one cycle, in the cycle out shows the value produced by a tick with w != 11. This includes ticks where the pattern value happens not to change.
- pos width is $clog2(N). Wrap is explicit compare-and-load, so N need not be a power of 2.

Test Plan:
- N=3, TICK_DIV=1: reset=0 then release, w=00 for 4 cycles -> out 101 during reset; then 010,101,010,101; step=1 each cycle.
- N=3, TICK_DIV=1: from CALM_EDGE, w=01 for 4 cycles -> out 001,010,100,001 (wrap); then w=00 -> 101.
- N=5, TICK_DIV=4: w=10 from reset -> out 10000 after 4 cycles, 01000 after 8, then 00100; step pulses every 4th cycle only; out stable in between.
- N=5, TICK_DIV=1: sweep w=01 to pos=2 (00100), then switch to w=10 -> 00010, 00001, 10000 (reversal from current pos, LSB wrap).
- N=4, TICK_DIV=2: enable=0 for 6 cycles mid-sweep -> out, prescaler and step frozen. Then w=11 with enable=1 -> out held, step=0. Calm check: centre pattern = 0110.
- Async reset: assert reset=0 between clk edges during a sweep at 0100 -> out becomes 1001 before the next edge; after release, first tick with w=01 -> 0001.
